// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit owning the HI/LO registers
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid, i_funct      EX-stage R-type instruction and its funct field
//   i_rs_data, i_rt_data  forwarded operands
//   o_stall               combinational interlock toward the hazard unit
//   o_busy                an operation is in flight
//   o_mf_data             HI/LO value for an accepted MFHI/MFLO, else 0
//   o_hi, o_lo            architectural HI/LO contents
//   o_div_zero            one-cycle pulse when a divide by zero completes
//
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module ex_muldiv_unit #(
    parameter int NB_REG = 32,
    parameter int NB_OP  = 6,
    parameter int NB_CNT = $clog2(NB_REG + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [NB_OP-1:0]  i_funct,
    input  logic [NB_REG-1:0] i_rs_data,
    input  logic [NB_REG-1:0] i_rt_data,
    output logic              o_stall,
    output logic              o_busy,
    output logic [NB_REG-1:0] o_mf_data,
    output logic [NB_REG-1:0] o_hi,
    output logic [NB_REG-1:0] o_lo,
    output logic              o_div_zero
);
    localparam logic [NB_OP-1:0] F_MFHI  = NB_OP'(6'h10);
    localparam logic [NB_OP-1:0] F_MTHI  = NB_OP'(6'h11);
    localparam logic [NB_OP-1:0] F_MFLO  = NB_OP'(6'h12);
    localparam logic [NB_OP-1:0] F_MTLO  = NB_OP'(6'h13);
    localparam logic [NB_OP-1:0] F_MULT  = NB_OP'(6'h18);
    localparam logic [NB_OP-1:0] F_MULTU = NB_OP'(6'h19);
    localparam logic [NB_OP-1:0] F_DIV   = NB_OP'(6'h1A);
    localparam logic [NB_OP-1:0] F_DIVU  = NB_OP'(6'h1B);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [2*NB_REG-1:0] acc;
    logic [NB_REG-1:0]   opd;
    logic [NB_CNT-1:0]   count;
    logic                is_div, neg_q, neg_r, dz;

    logic is_mfhi, is_mthi, is_mflo, is_mtlo, mul_op, div_op, sgn;
    logic uses_hilo, accept, start_md, rs_neg, rt_neg;
    logic [NB_REG-1:0]   rs_mag, rt_mag, div_hi, div_lo;
    logic [NB_REG:0]     sum, trial;
    logic [2*NB_REG-1:0] mul_nxt, div_nxt, mul_res;

    assign is_mfhi   = i_funct == F_MFHI;
    assign is_mthi   = i_funct == F_MTHI;
    assign is_mflo   = i_funct == F_MFLO;
    assign is_mtlo   = i_funct == F_MTLO;
    assign mul_op    = (i_funct == F_MULT) || (i_funct == F_MULTU);
    assign div_op    = (i_funct == F_DIV) || (i_funct == F_DIVU);
    assign sgn       = (i_funct == F_MULT) || (i_funct == F_DIV);
    assign uses_hilo = is_mfhi || is_mthi || is_mflo || is_mtlo || mul_op || div_op;
    assign accept    = i_valid && uses_hilo && (state == IDLE);
    assign o_stall   = i_valid && uses_hilo && (state != IDLE);
    assign o_busy    = state != IDLE;
    assign o_mf_data = (accept && is_mfhi) ? o_hi : (accept && is_mflo) ? o_lo : '0;

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to double width makes one truncated product serve both
    // signed and unsigned multiplies.
    logic [2*NB_REG-1:0] fast_prod;
    assign fast_prod = {{NB_REG{sgn & i_rs_data[NB_REG-1]}}, i_rs_data} *
                       {{NB_REG{sgn & i_rt_data[NB_REG-1]}}, i_rt_data};
    assign start_md  = accept && div_op;
`else
    assign start_md  = accept && (mul_op || div_op);
`endif

    assign rs_neg = sgn & i_rs_data[NB_REG-1];
    assign rt_neg = sgn & i_rt_data[NB_REG-1];
    assign rs_mag = rs_neg ? -i_rs_data : i_rs_data;
    assign rt_mag = rt_neg ? -i_rt_data : i_rt_data;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder ends up as the dividend magnitude, which the sign fix restores to rs.
    always_comb begin
        sum     = {1'b0, acc[2*NB_REG-1:NB_REG]} + {1'b0, opd};
        mul_nxt = acc[0] ? {sum, acc[NB_REG-1:1]} : {1'b0, acc[2*NB_REG-1:1]};
        trial   = acc[2*NB_REG-1:NB_REG-1] - {1'b0, opd};
        div_nxt = trial[NB_REG] ? {acc[2*NB_REG-2:0], 1'b0}
                                : {trial[NB_REG-1:0], acc[NB_REG-2:0], 1'b1};
        mul_res = neg_q ? -acc : acc;
        div_lo  = dz ? '1 : neg_q ? -acc[NB_REG-1:0] : acc[NB_REG-1:0];
        div_hi  = neg_r ? -acc[2*NB_REG-1:NB_REG] : acc[2*NB_REG-1:NB_REG];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_md ? RUN : IDLE;
            RUN:     state_nxt = (count == NB_CNT'(1)) ? FIX : RUN;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc        <= '0;
            opd        <= '0;
            count      <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz         <= 1'b0;
            o_hi       <= '0;
            o_lo       <= '0;
            o_div_zero <= 1'b0;
        end else begin
            o_div_zero <= (state == FIX) && is_div && dz;
            if (start_md) begin
                is_div <= div_op;
                neg_q  <= rs_neg ^ rt_neg;
                neg_r  <= rs_neg;
                dz     <= i_rt_data == '0;
                count  <= NB_CNT'(NB_REG);
                opd    <= div_op ? rt_mag : rs_mag;
                acc    <= {{NB_REG{1'b0}}, div_op ? rs_mag : rt_mag};
            end else if (state == RUN) begin
                acc   <= is_div ? div_nxt : mul_nxt;
                count <= count - 1'b1;
            end
            if (state == FIX) {o_hi, o_lo} <= is_div ? {div_hi, div_lo} : mul_res;
            if (accept && is_mthi) o_hi <= i_rs_data;
            if (accept && is_mtlo) o_lo <= i_rs_data;
`ifdef MULDIV_FAST_MUL_EN
            if (accept && mul_op) {o_hi, o_lo} <= fast_prod;
`endif
        end
    end
endmodule
